// File: rtl/bit_remap_pkg.sv
// Shared types for the bit remapper: table entry layout, config FSM states
// and the reset-default mapping.
package bit_remap_pkg;

  // Widest source-index field an entry can hold (SRC_W up to 256).
  localparam int unsigned SEL_MAX_W = 8;

  typedef struct packed {
    logic                 en;
    logic [SEL_MAX_W-1:0] sel;
  } remap_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DIRTY,
    COMMIT
  } cfg_state_e;

  // Bus entries default to identity (disabled past the source width);
  // scalar taps default to the low source bits, always enabled.
  function automatic remap_entry_t default_entry(input int unsigned idx,
                                                 input int unsigned dst_w,
                                                 input int unsigned src_w);
    remap_entry_t e;
    e = '0;
    if (idx < dst_w) begin
      e.sel = SEL_MAX_W'(idx % src_w);
      e.en  = (idx < src_w);
    end else begin
      e.sel = SEL_MAX_W'((idx - dst_w) % src_w);
      e.en  = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/bit_remap_table.sv
// Shadow/active mapping table with validated writes and an atomic commit.
module bit_remap_table
  import bit_remap_pkg::*;
#(
  parameter int unsigned SRC_W    = 8,
  parameter int unsigned DST_W    = 8,
  parameter int unsigned N_SCALAR = 1,
  localparam int unsigned SEL_W   = $clog2(SRC_W),
  localparam int unsigned N_ENT   = DST_W + N_SCALAR,
  localparam int unsigned ADDR_W  = $clog2(N_ENT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic                     cfg_en,
  input  logic                     cfg_commit,
  output logic                     cfg_err,
  output remap_entry_t [N_ENT-1:0] active_tbl
);

  cfg_state_e                state_q;
  remap_entry_t [N_ENT-1:0]  shadow_q;
  remap_entry_t [N_ENT-1:0]  active_q;
  logic                      err_q;
  logic                      wr_acc;
  logic                      wr_bad;
  logic                      wr_ok;
  remap_entry_t              wr_entry;

  assign cfg_ready  = (state_q != COMMIT);
  assign cfg_err    = err_q;
  assign active_tbl = active_q;

  assign wr_acc   = cfg_valid && cfg_ready;
  assign wr_bad   = (32'(cfg_addr) >= N_ENT) || (32'(cfg_sel) >= SRC_W);
  assign wr_ok    = wr_acc && !wr_bad;
  assign wr_entry = '{en: cfg_en, sel: SEL_MAX_W'(cfg_sel)};

  // A write accepted alongside a commit lands in shadow before the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < N_ENT; i++) begin
        shadow_q[i] <= default_entry(i, DST_W, SRC_W);
        active_q[i] <= default_entry(i, DST_W, SRC_W);
      end
    end else begin
      err_q <= wr_acc && wr_bad;
      if (wr_ok) begin
        for (int unsigned i = 0; i < N_ENT; i++) begin
          if (32'(cfg_addr) == i) shadow_q[i] <= wr_entry;
        end
      end
      case (state_q)
        IDLE:    if (wr_ok) state_q <= DIRTY;
        DIRTY:   if (cfg_commit) state_q <= COMMIT;
        COMMIT: begin
          active_q <= shadow_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bit_remap_stream.sv
// Registered bit remapper on a valid/ready stream; routing comes from the
// active half of a double-buffered, runtime-programmable table.
module bit_remap_stream
  import bit_remap_pkg::*;
#(
  parameter int unsigned SRC_W    = 8,
  parameter int unsigned DST_W    = 8,
  parameter int unsigned N_SCALAR = 1,
  localparam int unsigned SEL_W   = $clog2(SRC_W),
  localparam int unsigned N_ENT   = DST_W + N_SCALAR,
  localparam int unsigned ADDR_W  = $clog2(N_ENT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SRC_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DST_W-1:0]    out_bus,
  output logic [N_SCALAR-1:0] out_scalar,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic                cfg_en,
  input  logic                cfg_commit,
  output logic                cfg_err
);

  remap_entry_t [N_ENT-1:0] active_tbl;
  logic [DST_W-1:0]         mux_bus;
  logic [N_SCALAR-1:0]      mux_scalar;
  logic                     beat_acc;

  bit_remap_table #(
    .SRC_W    (SRC_W),
    .DST_W    (DST_W),
    .N_SCALAR (N_SCALAR)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_sel    (cfg_sel),
    .cfg_en     (cfg_en),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .active_tbl (active_tbl)
  );

  // One source-bit mux per destination; disabled entries drive 0.
  always_comb begin
    mux_bus    = '0;
    mux_scalar = '0;
    for (int unsigned i = 0; i < DST_W; i++) begin
      for (int unsigned j = 0; j < SRC_W; j++) begin
        if (active_tbl[i].en && (32'(active_tbl[i].sel) == j)) mux_bus[i] = in_data[j];
      end
    end
    for (int unsigned k = 0; k < N_SCALAR; k++) begin
      for (int unsigned j = 0; j < SRC_W; j++) begin
        if (active_tbl[DST_W+k].en && (32'(active_tbl[DST_W+k].sel) == j)) begin
          mux_scalar[k] = in_data[j];
        end
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign beat_acc = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_bus    <= '0;
      out_scalar <= '0;
    end else if (beat_acc) begin
      out_valid  <= 1'b1;
      out_bus    <= mux_bus;
      out_scalar <= mux_scalar;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_remap_stream.sv
// Bench for bit_remap_stream: two instances (8->8+1 and 6->8+2) checked every
// cycle against a table-level model, plus directed literal expectations.
module tb_bit_remap_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid   [2];
  logic [7:0] in_data    [2];
  logic       out_ready  [2];
  logic       cfg_valid  [2];
  logic [3:0] cfg_addr   [2];
  logic [2:0] cfg_sel    [2];
  logic       cfg_en     [2];
  logic       cfg_commit [2];

  logic       a_in_ready, a_out_valid, a_cfg_ready, a_cfg_err;
  logic [7:0] a_out_bus;
  logic [0:0] a_out_scalar;
  logic       b_in_ready, b_out_valid, b_cfg_ready, b_cfg_err;
  logic [7:0] b_out_bus;
  logic [1:0] b_out_scalar;

  logic       ir_v [2];
  logic       ov_v [2];
  logic       cr_v [2];
  logic       ce_v [2];
  logic [7:0] bus_v [2];
  logic [1:0] sc_v [2];

  assign ir_v[0] = a_in_ready;   assign ir_v[1] = b_in_ready;
  assign ov_v[0] = a_out_valid;  assign ov_v[1] = b_out_valid;
  assign cr_v[0] = a_cfg_ready;  assign cr_v[1] = b_cfg_ready;
  assign ce_v[0] = a_cfg_err;    assign ce_v[1] = b_cfg_err;
  assign bus_v[0] = a_out_bus;   assign bus_v[1] = b_out_bus;
  assign sc_v[0] = {1'b0, a_out_scalar};
  assign sc_v[1] = b_out_scalar;

  bit_remap_stream #(.SRC_W(8), .DST_W(8), .N_SCALAR(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(a_in_ready), .in_data(in_data[0]),
    .out_valid(a_out_valid), .out_ready(out_ready[0]),
    .out_bus(a_out_bus), .out_scalar(a_out_scalar),
    .cfg_valid(cfg_valid[0]), .cfg_ready(a_cfg_ready), .cfg_addr(cfg_addr[0]),
    .cfg_sel(cfg_sel[0]), .cfg_en(cfg_en[0]), .cfg_commit(cfg_commit[0]),
    .cfg_err(a_cfg_err)
  );

  bit_remap_stream #(.SRC_W(6), .DST_W(8), .N_SCALAR(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(b_in_ready), .in_data(in_data[1][5:0]),
    .out_valid(b_out_valid), .out_ready(out_ready[1]),
    .out_bus(b_out_bus), .out_scalar(b_out_scalar),
    .cfg_valid(cfg_valid[1]), .cfg_ready(b_cfg_ready), .cfg_addr(cfg_addr[1]),
    .cfg_sel(cfg_sel[1]), .cfg_en(cfg_en[1]), .cfg_commit(cfg_commit[1]),
    .cfg_err(b_cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs [2] = '{0, 0};

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Reference model: tables as plain integer arrays, outputs as variables.
  int src_w [2] = '{8, 6};
  int dst_w [2] = '{8, 8};
  int nsc   [2] = '{1, 2};
  int sh_sel [2][16];
  int sh_en  [2][16];
  int ac_sel [2][16];
  int ac_en  [2][16];
  bit m_ov [2], m_dirty [2], m_commit [2], m_err [2];
  logic [7:0] m_bus [2];
  logic [1:0] m_sc [2];

  function automatic void mdl_reset(input int d);
    for (int e = 0; e < dst_w[d] + nsc[d]; e++) begin
      if (e < dst_w[d]) begin
        sh_sel[d][e] = e % src_w[d];
        sh_en[d][e]  = (e < src_w[d]) ? 1 : 0;
      end else begin
        sh_sel[d][e] = (e - dst_w[d]) % src_w[d];
        sh_en[d][e]  = 1;
      end
      ac_sel[d][e] = sh_sel[d][e];
      ac_en[d][e]  = sh_en[d][e];
    end
    m_ov[d] = 0; m_dirty[d] = 0; m_commit[d] = 0; m_err[d] = 0;
    m_bus[d] = '0; m_sc[d] = '0;
  endfunction

  function automatic void mdl_step(input int d);
    bit was_dirty;
    if (in_valid[d] && (!m_ov[d] || out_ready[d])) begin
      m_bus[d] = '0;
      m_sc[d]  = '0;
      for (int i = 0; i < dst_w[d]; i++)
        if (ac_en[d][i] != 0) m_bus[d][i] = in_data[d][ac_sel[d][i]];
      for (int k = 0; k < nsc[d]; k++)
        if (ac_en[d][dst_w[d]+k] != 0) m_sc[d][k] = in_data[d][ac_sel[d][dst_w[d]+k]];
      m_ov[d] = 1;
    end else if (out_ready[d]) begin
      m_ov[d] = 0;
    end
    m_err[d] = 0;
    if (m_commit[d]) begin
      for (int e = 0; e < 16; e++) begin
        ac_sel[d][e] = sh_sel[d][e];
        ac_en[d][e]  = sh_en[d][e];
      end
      m_commit[d] = 0;
    end else begin
      was_dirty = m_dirty[d];
      if (cfg_valid[d]) begin
        if (int'(cfg_addr[d]) >= dst_w[d] + nsc[d] || int'(cfg_sel[d]) >= src_w[d]) begin
          m_err[d] = 1;
        end else begin
          sh_sel[d][cfg_addr[d]] = int'(cfg_sel[d]);
          sh_en[d][cfg_addr[d]]  = cfg_en[d] ? 1 : 0;
          m_dirty[d] = 1;
        end
      end
      if (was_dirty && cfg_commit[d]) begin
        m_commit[d] = 1;
        m_dirty[d]  = 0;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) mdl_reset(d);
      else mdl_step(d);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        check("out_valid", d, 32'(ov_v[d]), 32'(m_ov[d]));
        check("in_ready", d, 32'(ir_v[d]), 32'(!m_ov[d] || out_ready[d]));
        check("cfg_ready", d, 32'(cr_v[d]), 32'(!m_commit[d]));
        check("cfg_err", d, 32'(ce_v[d]), 32'(m_err[d]));
        if (m_ov[d]) begin
          check("out_bus", d, 32'(bus_v[d]), 32'(m_bus[d]));
          check("out_scalar", d, 32'(sc_v[d]), 32'(m_sc[d]));
        end
        if (ov_v[d] && out_ready[d]) n_hs[d]++;
      end
    end
  end

  task automatic send(input int d, input logic [7:0] data);
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic lit_out(input string name, input int d, input logic [7:0] bus,
                         input logic [1:0] sc);
    check({name, "_valid"}, d, 32'(ov_v[d]), 32'd1);
    check({name, "_bus"}, d, 32'(bus_v[d]), 32'(bus));
    check({name, "_scalar"}, d, 32'(sc_v[d]), 32'(sc));
  endtask

  task automatic cfg_wr(input int d, input int addr, input int sel, input bit en,
                        input bit commit);
    @(posedge clk); #1;
    cfg_valid[d]  = 1'b1;
    cfg_addr[d]   = 4'(addr);
    cfg_sel[d]    = 3'(sel);
    cfg_en[d]     = en;
    cfg_commit[d] = commit;
    @(posedge clk); #1;
    cfg_valid[d]  = 1'b0;
    cfg_commit[d] = 1'b0;
  endtask

  task automatic stream(input int d, input int n, input int stall_at, input int stall_len);
    int k;
    int base;
    bit took;
    logic [7:0] held;
    k = 0; took = 0; held = '0;
    repeat (2) @(posedge clk);
    base = n_hs[d];
    for (int cyc = 0; cyc < 60 && k < n; cyc++) begin
      @(posedge clk); #1;
      if (took) k++;
      out_ready[d] = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid[d]  = (k < n);
      in_data[d]   = 8'(37 * k + 5);
      @(negedge clk);
      if (cyc == stall_at) held = bus_v[d];
      if (cyc >= stall_at && cyc < stall_at + stall_len) begin
        check("bp_in_ready", d, 32'(ir_v[d]), 32'd0);
        if (cyc > stall_at) check("bp_hold", d, 32'(bus_v[d]), 32'(held));
      end
      took = in_valid[d] && ir_v[d];
    end
    check("bp_done", d, 32'(k), 32'(n));
    @(posedge clk); #1;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bp_count", d, 32'(n_hs[d] - base), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
      cfg_valid[d] = 1'b0; cfg_addr[d] = '0; cfg_sel[d] = '0;
      cfg_en[d] = 1'b0; cfg_commit[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", d, 32'(ov_v[d]), 32'd0);
      check("rst_out_bus", d, 32'(bus_v[d]), 32'd0);
      check("rst_out_scalar", d, 32'(sc_v[d]), 32'd0);
      check("rst_cfg_ready", d, 32'(cr_v[d]), 32'd1);
      check("rst_cfg_err", d, 32'(ce_v[d]), 32'd0);
    end
    rst = 1'b0;

    // Reset-default tables: identity bus, bits 6/7 disabled on the 6-bit source.
    send(1, 8'h25); lit_out("def_b0", 1, 8'h25, 2'b01);
    send(1, 8'h3A); lit_out("def_b1", 1, 8'h3A, 2'b10);
    send(0, 8'h5C); lit_out("def_a0", 0, 8'h5C, 2'b00);
    send(0, 8'h01); lit_out("def_a1", 0, 8'h01, 2'b01);

    // Remap: entry0<-bit7, entries 3 and 7 disabled; beat in COMMIT cycle keeps identity.
    cfg_wr(0, 0, 7, 1'b1, 1'b0);
    cfg_wr(0, 3, 0, 1'b0, 1'b0);
    cfg_wr(0, 7, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    cfg_commit[0] = 1'b1;
    @(posedge clk); #1;
    cfg_commit[0] = 1'b0;
    check("commit_cfg_ready", 0, 32'(cr_v[0]), 32'd0);
    in_valid[0] = 1'b1; in_data[0] = 8'h08;
    @(posedge clk); #1;
    lit_out("commit_cycle_beat", 0, 8'h08, 2'b00);
    in_data[0] = 8'h80;
    @(posedge clk); #1;
    lit_out("remap_80", 0, 8'h01, 2'b00);
    in_data[0] = 8'h08;
    @(posedge clk); #1;
    lit_out("remap_08", 0, 8'h00, 2'b00);
    in_valid[0] = 1'b0;

    // Write together with commit in DIRTY: entry1<-bit5 is part of the commit.
    cfg_wr(0, 1, 2, 1'b1, 1'b0);
    cfg_wr(0, 1, 5, 1'b1, 1'b1);
    send(0, 8'h20); lit_out("wr_commit_same", 0, 8'h22, 2'b00);

    // Backpressure: 3-cycle stall mid-stream.
    stream(0, 6, 2, 3);

    // Rejected writes on the 6-bit instance: bad address, then bad select.
    cfg_wr(1, 10, 0, 1'b1, 1'b0);
    check("err_addr_pulse", 1, 32'(ce_v[1]), 32'd1);
    @(posedge clk); #1;
    check("err_addr_clear", 1, 32'(ce_v[1]), 32'd0);
    cfg_wr(1, 2, 6, 1'b1, 1'b0);
    check("err_sel_pulse", 1, 32'(ce_v[1]), 32'd1);
    @(posedge clk); #1;
    check("err_sel_clear", 1, 32'(ce_v[1]), 32'd0);
    cfg_commit[1] = 1'b1;
    @(posedge clk); #1;
    cfg_commit[1] = 1'b0;
    @(posedge clk); #1;
    check("err_still_idle", 1, 32'(cr_v[1]), 32'd1);
    send(1, 8'h25); lit_out("err_unchanged", 1, 8'h25, 2'b01);

    // Async reset with a held output beat.
    @(posedge clk); #1;
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 8'h3C;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("pre_rst_valid", 0, 32'(ov_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 0, 32'(ov_v[0]), 32'd0);
    check("arst_bus", 0, 32'(bus_v[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready[0] = 1'b1;
    send(0, 8'h80); lit_out("post_rst_80", 0, 8'h80, 2'b00);
    send(0, 8'h08); lit_out("post_rst_08", 0, 8'h08, 2'b00);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_remap_stream.md
Name: bit_remap_stream

Overview:
- Parametrised, registered bit-level remapper; successor to the static bus/scalar assign blocks in the netlist backend fixtures.
- Each destination bus bit and each scalar tap selects any source bit, or drives 0 when disabled.
- The mapping table is runtime-configurable through a shadow/active double buffer and committed atomically.
- Data moves on a valid/ready stream with one pipeline register. Used as a generic bit-routing leaf in generated test designs.

Parameters:
- SRC_W, 8, source bus width (>=2)
- DST_W, 8, destination bus width (>=1)
- N_SCALAR, 1, number of scalar output taps (>=1)
- SEL_W, $clog2(SRC_W), source-index width (derived, not overridable)
- N_ENT, DST_W+N_SCALAR, table entries (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  source beat valid
- in_ready  out  1  source beat accepted when in_valid&&in_ready
- in_data  in  SRC_W  source bus
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_bus  out  DST_W  remapped bus
- out_scalar  out  N_SCALAR  remapped scalar taps
- cfg_valid  in  1  table-write request
- cfg_ready  out  1  table-write accept
- cfg_addr  in  $clog2(N_ENT+1)  entry index: 0..DST_W-1 are bus bits; DST_W.. are scalars
- cfg_sel  in  SEL_W  source bit index
- cfg_en  in  1  entry enable; 0 forces output bit to 0
- cfg_commit  in  1  request copy of shadow table into active table
- cfg_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset, asynchronous: out_valid=0, out_bus=0, out_scalar=0, cfg_err=0, cfg_ready=1, FSM=IDLE.
- Reset table value, for both shadow and active: bus entry i has sel=i mod SRC_W, en=(i<SRC_W); scalar entry k has sel=k mod SRC_W, en=1.
- Datapath: out_bus[i] = active[i].en ? in_data[active[i].sel] : 0; scalars are computed the same way from entry DST_W+k. The result is registered: latency is 1 cycle from accept to out_valid.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - An accepted beat loads the output register and sets out_valid.
  - out_valid clears when out_ready && !(in_valid&&in_ready).
  - Full throughput: one beat per cycle under continuous ready.
  - Output data stays stable while out_valid && !out_ready.
- Config FSM:
  - IDLE: cfg_ready=1. A valid write moves to DIRTY.
  - DIRTY: cfg_ready=1; writes continue. cfg_commit moves to COMMIT.
  - COMMIT: lasts one cycle. cfg_ready=0; active<=shadow on the clock edge; returns to IDLE.
  - cfg_commit in IDLE is a no-op (tables already equal).
- Write rules:
  - A write is accepted when cfg_valid && cfg_ready.
  - A write with cfg_addr>=N_ENT or cfg_sel>=SRC_W is ignored: shadow is unchanged, cfg_err pulses the next cycle, and the FSM state is unchanged.
- Simultaneous events:
  - cfg_commit together with an accepted write in DIRTY: the write lands in shadow first, and the commit includes it.
  - A beat accepted in the COMMIT cycle uses the old active table. The first beat accepted after the COMMIT cycle uses the new table. A beat never mixes tables.
  - Config writes never stall the datapath.
- Reset mid-operation: an in-flight output beat is dropped, and both tables revert to reset values.

Decomposition:
- Shared package bit_remap_pkg holds the entry struct {en, sel}, the FSM state enum {IDLE, DIRTY, COMMIT}, and a function computing the reset-default entry from its index.
- One natural sub-module: bit_remap_table, containing the shadow/active arrays, the write/validation logic and the commit FSM, and exposing the flat active table.
- The top level holds the mux array and the output pipeline register.

Test Plan:
- Reset defaults, SRC_W=2, DST_W=2, N_SCALAR=1: in_data=2'b10 -> out_bus=2'b10, out_scalar=0. in_data=2'b01 -> out_bus=2'b01, out_scalar=1. out_valid one cycle after accept.
- Remap and commit, SRC_W=8, DST_W=8: write entry 0 sel=7 en=1 and entry 3 en=0, then commit. in_data=8'h80 -> out_bus=8'h01. in_data=8'h08 -> out_bus=8'h00 (entry 3 disabled, entry 0 selects bit 7=0). A beat accepted in the COMMIT cycle still yields the identity map.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_bus stable. Release -> beats emerge in order with no loss or duplication.
- Error writes: cfg_addr=N_ENT, then cfg_sel=SRC_W (SRC_W non-power-of-2, e.g. 6) -> cfg_err pulses once per write, FSM stays IDLE, outputs unchanged after commit.
- Write+commit same cycle: entry 1 sel=5 written together with cfg_commit in DIRTY -> the following beat with in_data=8'h20 gives out_bus[1]=1.
- Async reset asserted mid-stream with out_valid=1 -> out_valid=0 immediately, no clock needed. Identity table is restored on the next beat.
